// File: rtl/countdown_timer_counter.sv
// Countdown timer core: loads an HH:MM:SS.cc preset, counts down on clock_1ms rising edges,
// and raises a bounded alarm once the count reaches zero.
module countdown_timer_counter #(
   parameter int ALARM_TICKS = 300
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clock_1ms,
   input  logic       start_edge,
   input  logic       reset_edge,
   input  logic       load_edge,
   input  logic [4:0] load_hours,
   input  logic [5:0] load_minutes,
   input  logic [5:0] load_seconds,
   input  logic [6:0] load_centiseconds,
   output logic       running,
   output logic       expired,
   output logic       alarm,
   output logic [1:0] state,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic [6:0] centiseconds
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   state_t      state_q;
   logic        clock_1ms_prev;
   logic        tick;
   logic [15:0] alarm_count;

   logic [4:0]  preset_hours;
   logic [5:0]  preset_minutes;
   logic [5:0]  preset_seconds;
   logic [6:0]  preset_centiseconds;

   logic [4:0]  clamp_hours;
   logic [5:0]  clamp_minutes;
   logic [5:0]  clamp_seconds;
   logic [6:0]  clamp_centiseconds;

   logic [4:0]  dec_hours;
   logic [5:0]  dec_minutes;
   logic [5:0]  dec_seconds;
   logic [6:0]  dec_centiseconds;
   logic        count_zero;
   logic        dec_zero;

   assign tick    = clock_1ms & ~clock_1ms_prev;
   assign state   = state_q;
   assign running = (state_q == RUNNING);
   assign expired = (state_q == EXPIRED);

   assign clamp_hours        = (load_hours        > 5'd23) ? 5'd23 : load_hours;
   assign clamp_minutes      = (load_minutes      > 6'd59) ? 6'd59 : load_minutes;
   assign clamp_seconds      = (load_seconds      > 6'd59) ? 6'd59 : load_seconds;
   assign clamp_centiseconds = (load_centiseconds > 7'd99) ? 7'd99 : load_centiseconds;

   assign count_zero = (hours == 5'd0) && (minutes == 6'd0) &&
                       (seconds == 6'd0) && (centiseconds == 7'd0);

   // Borrow chain: each field wraps to its maximum and borrows from the next field up.
   always_comb begin
      dec_hours        = hours;
      dec_minutes      = minutes;
      dec_seconds      = seconds;
      dec_centiseconds = centiseconds - 7'd1;
      if (centiseconds == 7'd0) begin
         dec_centiseconds = 7'd99;
         if (seconds == 6'd0) begin
            dec_seconds = 6'd59;
            if (minutes == 6'd0) begin
               dec_minutes = 6'd59;
               dec_hours   = hours - 5'd1;
            end else begin
               dec_minutes = minutes - 6'd1;
            end
         end else begin
            dec_seconds = seconds - 6'd1;
         end
      end
   end

   assign dec_zero = (dec_hours == 5'd0) && (dec_minutes == 6'd0) &&
                     (dec_seconds == 6'd0) && (dec_centiseconds == 7'd0);

   // One priority chain per cycle: reset_edge, then load_edge, then start_edge, then tick.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q             <= IDLE;
         clock_1ms_prev      <= 1'b0;
         alarm               <= 1'b0;
         alarm_count         <= 16'd0;
         preset_hours        <= 5'd0;
         preset_minutes      <= 6'd0;
         preset_seconds      <= 6'd0;
         preset_centiseconds <= 7'd0;
         hours               <= 5'd0;
         minutes             <= 6'd0;
         seconds             <= 6'd0;
         centiseconds        <= 7'd0;
      end else begin
         clock_1ms_prev <= clock_1ms;
         if (reset_edge) begin
            hours        <= preset_hours;
            minutes      <= preset_minutes;
            seconds      <= preset_seconds;
            centiseconds <= preset_centiseconds;
            state_q      <= IDLE;
            alarm        <= 1'b0;
            alarm_count  <= 16'd0;
         end else if (load_edge && (state_q != RUNNING)) begin
            preset_hours        <= clamp_hours;
            preset_minutes      <= clamp_minutes;
            preset_seconds      <= clamp_seconds;
            preset_centiseconds <= clamp_centiseconds;
            hours               <= clamp_hours;
            minutes             <= clamp_minutes;
            seconds             <= clamp_seconds;
            centiseconds        <= clamp_centiseconds;
            state_q             <= IDLE;
            alarm               <= 1'b0;
            alarm_count         <= 16'd0;
         end else if (start_edge) begin
            case (state_q)
               IDLE:    if (!count_zero) state_q <= RUNNING;
               RUNNING: state_q <= PAUSED;
               PAUSED:  state_q <= RUNNING;
               default: state_q <= state_q;
            endcase
         end else if (tick) begin
            if ((state_q == RUNNING) && !count_zero) begin
               hours        <= dec_hours;
               minutes      <= dec_minutes;
               seconds      <= dec_seconds;
               centiseconds <= dec_centiseconds;
               if (dec_zero) begin
                  state_q     <= EXPIRED;
                  alarm       <= 1'b1;
                  alarm_count <= 16'(ALARM_TICKS);
               end
            end else if ((state_q == EXPIRED) && (alarm_count != 16'd0)) begin
               alarm_count <= alarm_count - 16'd1;
               if (alarm_count == 16'd1) alarm <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer_counter.sv
// Self-checking bench for countdown_timer_counter: a vector table with fixed expectations plus a
// per-cycle scoreboard fed by a total-centiseconds reference model.
module tb_countdown_timer_counter;

   localparam int ALARM_TICKS = 4;

   logic       clock;
   logic       reset_n;
   logic       clock_1ms;
   logic       start_edge;
   logic       reset_edge;
   logic       load_edge;
   logic [4:0] load_hours;
   logic [5:0] load_minutes;
   logic [5:0] load_seconds;
   logic [6:0] load_centiseconds;
   logic       running;
   logic       expired;
   logic       alarm;
   logic [1:0] state;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [6:0] centiseconds;

   countdown_timer_counter #(.ALARM_TICKS(ALARM_TICKS)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .clock_1ms(clock_1ms),
      .start_edge(start_edge),
      .reset_edge(reset_edge),
      .load_edge(load_edge),
      .load_hours(load_hours),
      .load_minutes(load_minutes),
      .load_seconds(load_seconds),
      .load_centiseconds(load_centiseconds),
      .running(running),
      .expired(expired),
      .alarm(alarm),
      .state(state),
      .hours(hours),
      .minutes(minutes),
      .seconds(seconds),
      .centiseconds(centiseconds)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef enum int {OP_LOAD, OP_START, OP_TICKS, OP_RESET, OP_STARTTICK, OP_RESETLOAD} op_t;

   typedef struct {
      op_t         op;
      int          lh, lm, ls, lc;
      int          n;
      logic [28:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [28:0] exp_q[$];
   int          compared = 0;
   int          mismatched = 0;

   // Reference model keeps the count as total centiseconds.
   int m_state, m_alarm, m_acnt, m_prev, m_preset, m_count;

   function automatic logic [28:0] packExp(int st, int al, int total);
      logic [1:0] s2;
      s2 = 2'(st);
      return {(st == 1), (st == 3), 1'(al), s2, 5'(total / 360000), 6'((total / 6000) % 60),
              6'((total / 100) % 60), 7'(total % 100)};
   endfunction

   function automatic int toTotal(int h, int m, int s, int c);
      return ((h * 60 + m) * 60 + s) * 100 + c;
   endfunction

   function automatic vec_t mk(op_t op, int lh, int lm, int ls, int lc, int n,
                               int st, int al, int eh, int em, int es, int ec);
      vec_t v;
      v.op = op; v.lh = lh; v.lm = lm; v.ls = ls; v.lc = lc; v.n = n;
      v.exp = packExp(st, al, toTotal(eh, em, es, ec));
      return v;
   endfunction

   task automatic modelReset();
      m_state = 0; m_alarm = 0; m_acnt = 0; m_prev = 0; m_preset = 0; m_count = 0;
   endtask

   task automatic modelStep(input int s, input int r, input int l, input int c1,
                            input int lh, input int lm, input int ls, input int lc);
      int tk;
      tk = (c1 != 0 && m_prev == 0) ? 1 : 0;
      m_prev = c1;
      if (r != 0) begin
         m_count = m_preset; m_state = 0; m_alarm = 0; m_acnt = 0;
      end else if (l != 0 && m_state != 1) begin
         m_preset = toTotal(lh > 23 ? 23 : lh, lm > 59 ? 59 : lm, ls > 59 ? 59 : ls, lc > 99 ? 99 : lc);
         m_count = m_preset; m_state = 0; m_alarm = 0; m_acnt = 0;
      end else if (s != 0) begin
         if (m_state == 0 && m_count > 0) m_state = 1;
         else if (m_state == 1) m_state = 2;
         else if (m_state == 2) m_state = 1;
      end else if (tk != 0) begin
         if (m_state == 1 && m_count > 0) begin
            m_count--;
            if (m_count == 0) begin m_state = 3; m_alarm = 1; m_acnt = ALARM_TICKS; end
         end else if (m_state == 3 && m_acnt > 0) begin
            m_acnt--;
            if (m_acnt == 0) m_alarm = 0;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [28:0] exp);
      logic [28:0] act;
      act = {running, expired, alarm, state, hours, minutes, seconds, centiseconds};
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got run=%0b exp=%0b alarm=%0b st=%0d %0d:%0d:%0d.%0d, required run=%0b exp=%0b alarm=%0b st=%0d %0d:%0d:%0d.%0d",
                  name, act[28], act[27], act[26], act[25:24], act[23:19], act[18:13], act[12:7], act[6:0],
                  exp[28], exp[27], exp[26], exp[25:24], exp[23:19], exp[18:13], exp[12:7], exp[6:0]);
      end
   endtask

   // Drives one clock cycle of inputs at the falling edge and scores the result a cycle later.
   task automatic runCycle(input logic s, input logic r, input logic l, input logic c1,
                           input int lh, input int lm, input int ls, input int lc);
      logic [28:0] e;
      start_edge = s; reset_edge = r; load_edge = l; clock_1ms = c1;
      load_hours = 5'(lh); load_minutes = 6'(lm); load_seconds = 6'(ls); load_centiseconds = 7'(lc);
      modelStep(int'(s), int'(r), int'(l), int'(c1), lh, lm, ls, lc);
      exp_q.push_back(packExp(m_state, m_alarm, m_count));
      @(posedge clock);
      @(negedge clock);
      e = exp_q.pop_front();
      checkOutput("scoreboard", e);
   endtask

   task automatic applyStimulus(input vec_t v);
      case (v.op)
         OP_LOAD:      runCycle(1'b0, 1'b0, 1'b1, 1'b0, v.lh, v.lm, v.ls, v.lc);
         OP_START:     runCycle(1'b1, 1'b0, 1'b0, 1'b0, v.lh, v.lm, v.ls, v.lc);
         OP_RESET:     runCycle(1'b0, 1'b1, 1'b0, 1'b0, v.lh, v.lm, v.ls, v.lc);
         OP_RESETLOAD: runCycle(1'b0, 1'b1, 1'b1, 1'b0, v.lh, v.lm, v.ls, v.lc);
         OP_STARTTICK: begin
            runCycle(1'b1, 1'b0, 1'b0, 1'b1, v.lh, v.lm, v.ls, v.lc);
            runCycle(1'b0, 1'b0, 1'b0, 1'b0, v.lh, v.lm, v.ls, v.lc);
         end
         default: begin
            for (int i = 0; i < v.n; i++) begin
               runCycle(1'b0, 1'b0, 1'b0, 1'b1, v.lh, v.lm, v.ls, v.lc);
               runCycle(1'b0, 1'b0, 1'b0, 1'b0, v.lh, v.lm, v.ls, v.lc);
            end
         end
      endcase
   endtask

   initial begin
      // op, load h/m/s/c, ticks, expected state, alarm, h/m/s/c
      vecs.push_back(mk(OP_LOAD,      0, 0, 1, 2, 0,   0, 0, 0, 0, 1, 2));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 2));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 101, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 1,   3, 1, 0, 0, 0, 0));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 3,   3, 1, 0, 0, 0, 0));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 1,   3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 2,   3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(OP_RESET,     0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 2));
      vecs.push_back(mk(OP_LOAD,      1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 1,   1, 0, 0, 59, 59, 99));
      vecs.push_back(mk(OP_LOAD,      0, 1, 0, 0, 0,   1, 0, 0, 59, 59, 99));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   2, 0, 0, 59, 59, 99));
      vecs.push_back(mk(OP_LOAD,      0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 1,   1, 0, 0, 0, 59, 99));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   2, 0, 0, 0, 59, 99));
      vecs.push_back(mk(OP_LOAD,      31, 63, 60, 127, 0, 0, 0, 23, 59, 59, 99));
      vecs.push_back(mk(OP_LOAD,      0, 0, 0, 50, 0,  0, 0, 0, 0, 0, 50));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 50));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 5,   1, 0, 0, 0, 0, 45));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 45));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 10,  2, 0, 0, 0, 0, 45));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 45));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 44));
      vecs.push_back(mk(OP_STARTTICK, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 44));
      vecs.push_back(mk(OP_LOAD,      0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 3,   0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(OP_LOAD,      0, 0, 0, 3, 0,   0, 0, 0, 0, 0, 3));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 2));
      vecs.push_back(mk(OP_LOAD,      0, 0, 0, 99, 0,  1, 0, 0, 0, 0, 2));
      vecs.push_back(mk(OP_TICKS,     0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(OP_RESET,     0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3));
      vecs.push_back(mk(OP_START,     0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3));
      vecs.push_back(mk(OP_RESETLOAD, 5, 5, 5, 5, 0,   0, 0, 0, 0, 0, 3));

      reset_n = 1'b0; clock_1ms = 1'b0; start_edge = 1'b0; reset_edge = 1'b0; load_edge = 1'b0;
      load_hours = '0; load_minutes = '0; load_seconds = '0; load_centiseconds = '0;
      modelReset();
      repeat (3) @(negedge clock);
      checkOutput("reset_state", 29'd0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vector_%0d", i), vecs[i].exp);
      end

      // Asynchronous reset in the middle of a run wipes preset and count.
      applyStimulus(mk(OP_START, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3));
      applyStimulus(mk(OP_TICKS, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2));
      #2 reset_n = 1'b0;
      #1 checkOutput("async_reset", 29'd0);
      modelReset();
      @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(mk(OP_RESET, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      checkOutput("preset_cleared", packExp(0, 0, 0));
      applyStimulus(mk(OP_START, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      checkOutput("start_zero_after_reset", packExp(0, 0, 0));

      // Load from EXPIRED while the alarm is still sounding.
      applyStimulus(mk(OP_LOAD,  0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2));
      applyStimulus(mk(OP_START, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
      applyStimulus(mk(OP_TICKS, 0, 0, 0, 0, 2, 3, 1, 0, 0, 0, 0));
      checkOutput("expired_alarm_on", packExp(3, 1, 0));
      applyStimulus(mk(OP_LOAD,  0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 7));
      checkOutput("load_from_expired", packExp(0, 0, 7));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
